// File: rtl/vx_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// vx_systolic_skew_feeder
//
// Upstream stage of the systolic array. Each handshake delivers one k-slice:
// column k of A and row k of B. The slice is re-timed into the diagonal
// wavefront the array expects, so lane i reaches the array i cycles after
// lane 0. A small FSM sequences a whole job: it clears the accumulators,
// feeds k_len slices, waits for the wavefront to drain, then pulses done.
//
// Ports
//   clk        clock, all logic on the rising edge
//   reset      asynchronous, active-high
//   start      begin a job; sampled only while idle
//   k_len      number of slices in the job; latched when start is accepted
//   in_valid   slice valid
//   in_ready   slice accepted when in_valid & in_ready (decoded from state only)
//   in_a_vec   A column k, lane i at [i*DATA_SIZE +: DATA_SIZE]
//   in_b_vec   B row k, same packing
//   arr_a      skewed A lanes to the array in_a
//   arr_b      skewed B lanes to the array in_b
//   acc_clear  one-cycle accumulator clear (ORed into the array reset)
//   busy       high whenever a job is in progress
//   done       one-cycle pulse: array results are final
// -----------------------------------------------------------------------------
module vx_systolic_skew_feeder #(
    parameter int MATRIX_SIZE = 3,
    parameter int DATA_SIZE   = 8,
    parameter int MAC_LATENCY = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [15:0]                           k_len,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0]      in_a_vec,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0]      in_b_vec,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] arr_a,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] arr_b,
    output logic                                  acc_clear,
    output logic                                  busy,
    output logic                                  done
);

    // Cycles for the last slice to cross the array diagonal and land in the
    // far-corner PE accumulator.
    localparam int          DRAIN_CYCLES = 2*MATRIX_SIZE - 2 + MAC_LATENCY;
    localparam logic [15:0] DRAIN_LAST   = 16'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] k_reg;
    logic [15:0] slice_cnt;
    logic [15:0] drain_cnt;
    logic        accept;
    logic        last_slice;
    logic        drain_end;

    assign accept     = in_valid && in_ready;
    // Only evaluated in FEED, where k_reg is known to be non-zero.
    assign last_slice = (slice_cnt == k_reg - 16'd1);
    assign drain_end  = (drain_cnt == DRAIN_LAST);

    // ---------------------------------------------------------------- state
    // NOTE: registers are written with <= so every flop samples the values
    // from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = S_CLEAR;
            S_CLEAR: state_next = (k_reg == 16'd0) ? S_DRAIN : S_FEED;
            S_FEED:  if (accept && last_slice) state_next = S_DRAIN;
            S_DRAIN: if (drain_end) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        in_ready  = 1'b0;
        acc_clear = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            S_IDLE:  busy      = 1'b0;
            S_CLEAR: acc_clear = 1'b1;
            S_FEED:  in_ready  = 1'b1;
            S_DRAIN: ;
            S_DONE:  done      = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // ------------------------------------------------------------- counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_reg     <= '0;
            slice_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                k_reg     <= k_len;
                slice_cnt <= '0;
                drain_cnt <= '0;
            end
            if (accept) begin
                slice_cnt <= slice_cnt + 16'd1;
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + 16'd1;
            end
        end
    end

    // ----------------------------------------------------------- delay lines
    // Lane i is an (i+1)-deep chain shifted every cycle. The head loads the
    // accepted slice, or zero in any cycle without an accept, so a stall
    // pushes a zero slice through all lanes together and keeps alignment.
    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        logic [DATA_SIZE-1:0] a_sr [i+1];
        logic [DATA_SIZE-1:0] b_sr [i+1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                // NOTE: these storage registers are reset on purpose; an
                // abandoned job must not leak stale operands into the array.
                for (int s = 0; s <= i; s++) begin
                    a_sr[s] <= '0;
                    b_sr[s] <= '0;
                end
            end else begin
                a_sr[0] <= accept ? in_a_vec[i*DATA_SIZE +: DATA_SIZE] : '0;
                b_sr[0] <= accept ? in_b_vec[i*DATA_SIZE +: DATA_SIZE] : '0;
                for (int s = 1; s <= i; s++) begin
                    a_sr[s] <= a_sr[s-1];
                    b_sr[s] <= b_sr[s-1];
                end
            end
        end

        assign arr_a[i] = a_sr[i];
        assign arr_b[i] = b_sr[i];
    end

endmodule

// File: tb/tb_vx_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_vx_systolic_skew_feeder
//
// Directed bench for the skew feeder with N=3, 8-bit data. A behavioural
// 3x3 output-stationary systolic array sits downstream of the DUT so the
// final C = A*B can be compared against hand-computed matrices.
// -----------------------------------------------------------------------------
module tb_vx_systolic_skew_feeder;

    logic            clk;
    logic            reset;
    logic            start;
    logic [15:0]     k_len;
    logic            in_valid;
    logic            in_ready;
    logic [23:0]     in_a_vec;
    logic [23:0]     in_b_vec;
    logic [2:0][7:0] arr_a;
    logic [2:0][7:0] arr_b;
    logic            acc_clear;
    logic            busy;
    logic            done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int clr_cnt = 0;
    int rdy_cnt = 0;

    vx_systolic_skew_feeder #(
        .MATRIX_SIZE(3),
        .DATA_SIZE  (8),
        .MAC_LATENCY(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a_vec (in_a_vec),
        .in_b_vec (in_b_vec),
        .arr_a    (arr_a),
        .arr_b    (arr_b),
        .acc_clear(acc_clear),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_clear) clr_cnt <= clr_cnt + 1;
        if (in_ready)  rdy_cnt <= rdy_cnt + 1;
    end

    // ---------------------------------------------- downstream array model
    // PE(i,j): a enters row i from the left, b enters column j from the top,
    // each PE forwards its operands one cycle later and accumulates a*b.
    logic [7:0] pa   [3][3];
    logic [7:0] pb   [3][3];
    logic [7:0] acc  [3][3];
    logic [7:0] m_ain[3][3];
    logic [7:0] m_bin[3][3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            m_ain[i][0] = arr_a[i];
            m_bin[0][i] = arr_b[i];
            for (int j = 1; j < 3; j++) begin
                m_ain[i][j] = pa[i][j-1];
                m_bin[j][i] = pb[j-1][i];
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (reset || acc_clear) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end else begin
                    pa[i][j]  <= m_ain[i][j];
                    pb[i][j]  <= m_bin[i][j];
                    acc[i][j] <= acc[i][j] + m_ain[i][j] * m_bin[i][j];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] k, output int start_edge);
        start = 1'b1;
        k_len = k;
        tick();
        start_edge = cyc;
        start = 1'b0;
        k_len = 16'd7;  // changed after the accept: the job must use the latched value
        n_cmp++;
        if (acc_clear !== 1'b1) begin
            n_err++;
            $display("FAIL acc_clear_after_start got %b want 1", acc_clear);
        end
    endtask

    task automatic feed(input logic [7:0] a0, a1, a2, b0, b1, b2, output int acc_edge);
        int budget;
        budget   = 20;
        in_a_vec = {a2, a1, a0};
        in_b_vec = {b2, b1, b0};
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL feed_ready got %b want 1", in_ready);
        end
        tick();
        acc_edge = cyc;
        in_valid = 1'b0;
        in_a_vec = '0;
        in_b_vec = '0;
    endtask

    task automatic wait_done(output int at);
        int b;
        b  = 0;
        at = -1;
        while (done !== 1'b1 && b < 100) begin
            tick();
            b++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL done_timeout got done=%b want 1 within 100 cycles", done);
        end else begin
            at = cyc;
        end
    endtask

    task automatic check_matrix(input string tag, input bit ramp, input logic [7:0] val);
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                e = ramp ? 8'(3*i + j + 1) : val;
                n_cmp++;
                if (acc[i][j] !== e) begin
                    n_err++;
                    $display("FAIL %s c[%0d][%0d] got %0d want %0d", tag, i, j, acc[i][j], e);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_cmp++;
        if (arr_a !== 24'd0 || arr_b !== 24'd0 || in_ready !== 1'b0 ||
            acc_clear !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s got a=%h b=%h rdy=%b clr=%b busy=%b done=%b want all 0",
                     tag, arr_a, arr_b, in_ready, acc_clear, busy, done);
        end
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        #3;
        check_idle_outputs("reset_outputs");
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_reset_mid_job();
        int s, f;
        do_start(16'd3, s);
        feed(8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, f);
        n_cmp++;
        if (arr_a[0] !== 8'd5 || arr_b[0] !== 8'd8 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_job_lane0 got a0=%0d b0=%0d busy=%b want 5 8 1",
                     arr_a[0], arr_b[0], busy);
        end
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("async_reset_mid_feed");
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        check_idle_outputs("after_mid_reset_idle");
    endtask

    // A = I, B = [1..9] row-major: C = B.
    task automatic test_identity();
        int s, f, l, d;
        do_start(16'd3, s);
        feed(8'd1, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, f);
        feed(8'd0, 8'd1, 8'd0, 8'd4, 8'd5, 8'd6, l);
        feed(8'd0, 8'd0, 8'd1, 8'd7, 8'd8, 8'd9, l);
        // Cycle l+1: lane 2 shows slice 0, lane 0 shows slice 2.
        n_cmp++;
        if (arr_a[2] !== 8'd0 || arr_a[0] !== 8'd0 || arr_b[0] !== 8'd7 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL skew_t1 got a2=%0d a0=%0d b0=%0d rdy=%b want 0 0 7 0",
                     arr_a[2], arr_a[0], arr_b[0], in_ready);
        end
        tick();
        n_cmp++;
        if (arr_a[2] !== 8'd0 || arr_b[1] !== 8'd8 || arr_b[0] !== 8'd0) begin
            n_err++;
            $display("FAIL skew_t2 got a2=%0d b1=%0d b0=%0d want 0 8 0", arr_a[2], arr_b[1], arr_b[0]);
        end
        tick();
        n_cmp++;
        if (arr_a[2] !== 8'd1 || arr_b[2] !== 8'd9 || arr_a[1] !== 8'd0) begin
            n_err++;
            $display("FAIL skew_t3 got a2=%0d b2=%0d a1=%0d want 1 9 0", arr_a[2], arr_b[2], arr_a[1]);
        end
        wait_done(d);
        n_cmp++;
        if (d - l !== 5) begin
            n_err++;
            $display("FAIL identity_done_latency got %0d want 5", d - l);
        end
        check_matrix("identity", 1'b1, 8'd0);
        n_cmp++;
        if (arr_a !== 24'd0 || arr_b !== 24'd0) begin
            n_err++;
            $display("FAIL lines_flushed_at_done got a=%h b=%h want 0", arr_a, arr_b);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_single_pulse got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    // Same job with two idle cycles after slice 1: same result, done 2 cycles later.
    task automatic test_stall();
        int s, f, l, d;
        do_start(16'd3, s);
        feed(8'd1, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, f);
        feed(8'd0, 8'd1, 8'd0, 8'd4, 8'd5, 8'd6, l);
        tick();
        tick();
        feed(8'd0, 8'd0, 8'd1, 8'd7, 8'd8, 8'd9, l);
        wait_done(d);
        n_cmp++;
        if (d - f !== 9) begin
            n_err++;
            $display("FAIL stall_done_slip got %0d want 9", d - f);
        end
        check_matrix("stall", 1'b1, 8'd0);
        tick();
    endtask

    // A = B = all 2s: each C = 3 * 4 = 12.
    task automatic test_all_twos();
        int s, f, d;
        do_start(16'd3, s);
        tick();
        n_cmp++;
        if (acc_clear !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL clear_one_cycle got clr=%b rdy=%b want 0 1", acc_clear, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            feed(8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, f);
        end
        wait_done(d);
        check_matrix("all_twos", 1'b0, 8'd12);
        tick();
    endtask

    // start during FEED and in the DONE cycle must be ignored. A = B = all 1s.
    task automatic test_ignored_start();
        int s, f, d, c0;
        c0 = clr_cnt;
        do_start(16'd3, s);
        feed(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, f);
        start = 1'b1;
        feed(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, f);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || acc_clear !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_feed got busy=%b clr=%b want 1 0", busy, acc_clear);
        end
        feed(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, f);
        wait_done(d);
        check_matrix("ones", 1'b0, 8'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || acc_clear !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_done got busy=%b clr=%b want 0 0", busy, acc_clear);
        end
        tick();
        n_cmp++;
        if (clr_cnt - c0 !== 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL clear_count got %0d busy=%b want 1 0", clr_cnt - c0, busy);
        end
    endtask

    // k_len = 0: CLEAR, DRAIN, DONE with no slice requested.
    task automatic test_zero_len();
        int s, d, r0, c0;
        r0 = rdy_cnt;
        c0 = clr_cnt;
        do_start(16'd0, s);
        wait_done(d);
        n_cmp++;
        if (d - s !== 6) begin
            n_err++;
            $display("FAIL zero_len_done_latency got %0d want 6", d - s);
        end
        n_cmp++;
        if (rdy_cnt - r0 !== 0 || clr_cnt - c0 !== 1) begin
            n_err++;
            $display("FAIL zero_len_counts got rdy=%0d clr=%0d want 0 1", rdy_cnt - r0, clr_cnt - c0);
        end
        check_matrix("zero_len", 1'b0, 8'd0);
        tick();
        check_idle_outputs("zero_len_back_idle");
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        k_len    = '0;
        in_valid = 1'b0;
        in_a_vec = '0;
        in_b_vec = '0;
        test_reset();
        test_reset_mid_job();
        test_identity();
        test_stall();
        test_all_twos();
        test_ignored_start();
        test_zero_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
